// File: rtl/tcp_pkg.sv
// Shared types and helpers for the TCP transmit segment buffer.
// Sequence numbers compare modulo 2^32 so a window straddling the wrap still orders correctly.
package tcp_pkg;

  localparam int ACK_TIMEOUT_DEF = 200_000_000;
  localparam int RETX_W          = 8;

  typedef struct packed {
    logic [31:0]       seq;
    logic [15:0]       len;
    logic [15:0]       chksum;
    logic              sent;
    logic [RETX_W-1:0] retx_cnt;
  } slot_meta_t;

  // a >= b in sequence space: true when (a - b) is non-negative as a signed 32-bit value
  function automatic logic seq_ge(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    return !diff[31];
  endfunction

endpackage

// File: rtl/tcp_seg_ram.sv
// Simple dual-port segment payload RAM, one write port and one registered read port.
module tcp_seg_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tcp_tx_seg_buffer.sv
// Ring of TCP transmit segment slots held until cumulatively ACKed, with
// timeout-driven go-back-N retransmission starting from the oldest unacked slot.
module tcp_tx_seg_buffer
  import tcp_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_WORDS  = 512,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int MAX_RETX    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_i,
  input  logic [31:0]                wdat_i,
  input  logic                       wr_eop_i,
  input  logic [15:0]                wdat_len_i,
  input  logic [15:0]                wdat_chksum_i,
  output logic                       wr_full_o,
  output logic                       rd_avail_o,
  input  logic                       rd_start_i,
  input  logic                       rd_i,
  input  logic                       rd_stop_i,
  output logic [31:0]                rdat_o,
  output logic [15:0]                rd_len_o,
  output logic [15:0]                rd_chksum_o,
  output logic [31:0]                rd_seq_num_o,
  output logic                       rd_retx_o,
  input  logic [31:0]                seq_num_i,
  input  logic                       ack_valid_i,
  input  logic [31:0]                ack_num_i,
  input  logic                       flush_i,
  output logic                       ack_o,
  output logic                       retx_fail_o,
  output logic [$clog2(NUM_SLOTS):0] used_o
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int WW = $clog2(SLOT_WORDS);
  localparam int CW = PW + 1;
  localparam int AW = PW + WW;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, snd_ptr_q, snd_ptr_d, ack_ptr_q, ack_ptr_d;
  logic [CW-1:0] count_q, count_d, pend_q, pend_d, inflight_q, inflight_d;
  logic [WW-1:0] wr_word_q, wr_word_d, rd_word_q, rd_word_d, rd_addr_word;
  logic [31:0]   ack_num_q, ack_num_d, timer_q, timer_d;
  logic          reading_q, reading_d, timer_run_q, timer_run_d;
  logic          rewind_pend_q, rewind_pend_d, retx_fail_q, retx_fail_d, ack_q, ack_d;
  slot_meta_t    meta_q [NUM_SLOTS];
  slot_meta_t    meta_d [NUM_SLOTS];
  slot_meta_t    head;

  logic full, avail, wr_acc, eop_acc, start_acc, rd_acc, stop_acc;
  logic rel, expire, rewind, ram_we, ram_re;

  always_comb begin
    full       = (count_q == CW'(NUM_SLOTS));
    head       = meta_q[ack_ptr_q];
    inflight_q = count_q - pend_q;
    // Only slots between ack_ptr and snd_ptr are in flight; a rewound head waits for its resend.
    rel        = (count_q != '0) && (inflight_q != '0) && head.sent &&
                 seq_ge(ack_num_q, head.seq + 32'(head.len));
    expire     = timer_run_q && (timer_q == '0) && !rel;
    rewind     = !reading_q && (expire || rewind_pend_q);
    avail      = !reading_q && !rewind_pend_q && !expire && (pend_q != '0);

    wr_acc     = wr_i && !full;
    eop_acc    = wr_eop_i && !full;
    start_acc  = rd_start_i && avail;
    rd_acc     = rd_i && reading_q;
    stop_acc   = rd_stop_i && reading_q;

    meta_d        = meta_q;
    wr_ptr_d      = wr_ptr_q;
    snd_ptr_d     = snd_ptr_q;
    ack_ptr_d     = ack_ptr_q;
    wr_word_d     = wr_word_q;
    rd_word_d     = rd_word_q;
    reading_d     = reading_q;
    ack_num_d     = ack_valid_i ? ack_num_i : ack_num_q;
    retx_fail_d   = retx_fail_q;
    rewind_pend_d = rewind_pend_q;
    ack_d         = rel;
    rd_addr_word  = start_acc ? '0 : rd_word_q;

    if (wr_acc) wr_word_d = wr_word_q + 1'b1;
    if (eop_acc) begin
      meta_d[wr_ptr_q].len      = wdat_len_i;
      meta_d[wr_ptr_q].chksum   = wdat_chksum_i;
      meta_d[wr_ptr_q].sent     = 1'b0;
      meta_d[wr_ptr_q].retx_cnt = '0;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      wr_word_d = '0;
    end

    // Word 0 is fetched at start, so each rd_i fetches the following word.
    if (start_acc) begin
      if (!meta_q[snd_ptr_q].sent) meta_d[snd_ptr_q].seq = seq_num_i;
      reading_d = 1'b1;
      rd_word_d = WW'(1);
    end
    if (rd_acc) rd_word_d = rd_word_q + 1'b1;
    if (stop_acc) begin
      meta_d[snd_ptr_q].sent = 1'b1;
      snd_ptr_d = snd_ptr_q + 1'b1;
      rd_word_d = '0;
      reading_d = 1'b0;
    end

    if (rel) ack_ptr_d = ack_ptr_q + 1'b1;
    count_d = count_q + CW'(eop_acc) - CW'(rel);
    pend_d  = pend_q + CW'(eop_acc) - CW'(stop_acc);

    if (expire) begin
      if (head.retx_cnt != '1) meta_d[ack_ptr_q].retx_cnt = head.retx_cnt + 1'b1;
      if (int'(head.retx_cnt) + 1 >= MAX_RETX) retx_fail_d = 1'b1;
      if (reading_q) rewind_pend_d = 1'b1;
    end
    if (rewind) begin
      snd_ptr_d     = ack_ptr_d;
      pend_d        = count_d;
      rewind_pend_d = 1'b0;
    end

    inflight_d  = count_d - pend_d;
    timer_run_d = (inflight_d != '0) && !rewind_pend_d;
    if (!timer_run_d)                timer_d = '0;
    else if (rel || !timer_run_q)    timer_d = 32'(ACK_TIMEOUT - 1);
    else                             timer_d = timer_q - 1'b1;

    if (flush_i) begin
      wr_ptr_d      = '0;
      snd_ptr_d     = '0;
      ack_ptr_d     = '0;
      count_d       = '0;
      pend_d        = '0;
      wr_word_d     = '0;
      rd_word_d     = '0;
      reading_d     = 1'b0;
      timer_d       = '0;
      timer_run_d   = 1'b0;
      rewind_pend_d = 1'b0;
      retx_fail_d   = 1'b0;
      ack_d         = 1'b0;
    end

    ram_we = wr_acc && !flush_i;
    ram_re = start_acc || rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      snd_ptr_q     <= '0;
      ack_ptr_q     <= '0;
      count_q       <= '0;
      pend_q        <= '0;
      wr_word_q     <= '0;
      rd_word_q     <= '0;
      reading_q     <= 1'b0;
      ack_num_q     <= '0;
      timer_q       <= '0;
      timer_run_q   <= 1'b0;
      rewind_pend_q <= 1'b0;
      retx_fail_q   <= 1'b0;
      ack_q         <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) meta_q[i] <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      snd_ptr_q     <= snd_ptr_d;
      ack_ptr_q     <= ack_ptr_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      wr_word_q     <= wr_word_d;
      rd_word_q     <= rd_word_d;
      reading_q     <= reading_d;
      ack_num_q     <= ack_num_d;
      timer_q       <= timer_d;
      timer_run_q   <= timer_run_d;
      rewind_pend_q <= rewind_pend_d;
      retx_fail_q   <= retx_fail_d;
      ack_q         <= ack_d;
      meta_q        <= meta_d;
    end
  end

  tcp_seg_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i ({wr_ptr_q, wr_word_q}),
    .wdata_i (wdat_i),
    .re_i    (ram_re),
    .raddr_i ({snd_ptr_q, rd_addr_word}),
    .rdata_o (rdat_o)
  );

  assign wr_full_o    = full;
  assign rd_avail_o   = avail;
  assign rd_seq_num_o = meta_q[snd_ptr_q].seq;
  assign rd_len_o     = meta_q[snd_ptr_q].len;
  assign rd_chksum_o  = meta_q[snd_ptr_q].chksum;
  assign rd_retx_o    = meta_q[snd_ptr_q].sent;
  assign ack_o        = ack_q;
  assign retx_fail_o  = retx_fail_q;
  assign used_o       = count_q;

endmodule
